ports_frame_packer: RTL and testbench

- Collects DEPTH signed W-bit samples over a valid/ready input handshake and presents them as one frame on an unpacked-array output port.
- Also presents the frame's signed sum and a running `integer` count of delivered frames.
- Sits directly upstream of the port-rule test modules. It drives their inputs with every port kind they accept: `input var`, `output var integer`, `output wire logic signed`, and unpacked-array ports.
- Used as the producer stage in end-to-end port elaboration and simulation tests.

---
 rtl/ports_frame_packer.sv | 95 +++++++++
 tb/tb_ports_frame_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ports_frame_packer.sv
// ports_frame_packer
// Collects DEPTH signed W-bit samples over a valid/ready handshake and presents
// them as one registered frame, together with the frame's signed sum and a
// running count of frames handed off downstream.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     upstream sample valid
//   in_data      signed sample value
//   in_ready     block accepts a sample this cycle (state decode only)
//   out_valid    a complete frame is being presented (registered)
//   out_ready    downstream consumes the frame
//   out_frame    frame samples, index 0 holds the first sample accepted
//   out_sum      sign-extended sum of the frame samples
//   frame_count  frames handed off since reset, wraps in 32-bit two's complement
module ports_frame_packer #(
    parameter  int unsigned W     = 6,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned SUM_W = W + $clog2(DEPTH)
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  var  logic                    in_valid,
    input  wire logic signed [W-1:0]     in_data,
    output wire logic                    in_ready,
    output var  logic                    out_valid,
    input  wire logic                    out_ready,
    output var  logic signed [W-1:0]     out_frame [DEPTH-1:0],
    output wire logic signed [SUM_W-1:0] out_sum,
    output var  integer                  frame_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                    state_q;
    logic        [IDX_W-1:0]   idx_q;
    logic signed [SUM_W-1:0]   acc_q;
    logic signed [SUM_W-1:0]   acc_d;
    logic                      last_c;

    // Sum is sized so DEPTH copies of the most negative sample cannot overflow.
    assign acc_d    = acc_q + {{(SUM_W-W){in_data[W-1]}}, in_data};
    assign last_c   = (idx_q == IDX_W'(DEPTH - 1));
    assign in_ready = (state_q == FILL);
    assign out_sum  = acc_q;

    // Frame collection and handoff; handoff cycle never accepts a sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            out_valid   <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            frame_count <= 0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                out_frame[i] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        out_frame[idx_q] <= in_data;
                        acc_q            <= acc_d;
                        if (last_c) begin
                            idx_q     <= '0;
                            state_q   <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Old frame contents stay visible until overwritten.
                    if (out_ready) begin
                        state_q     <= FILL;
                        out_valid   <= 1'b0;
                        acc_q       <= '0;
                        frame_count <= frame_count + 1;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ports_frame_packer.sv
module tb_ports_frame_packer;

    localparam int unsigned W     = 6;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SUM_W = W + $clog2(DEPTH);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic signed [W-1:0]     in_data;
    wire                     in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [W-1:0]     out_frame [DEPTH-1:0];
    wire signed [SUM_W-1:0]  out_sum;
    integer                  frame_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    ports_frame_packer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_frame   (out_frame),
        .out_sum     (out_sum),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Reference: the samples accepted since the last handoff form the frame.
    int q[$];
    int m_frame [DEPTH];
    int m_count;

    function automatic int qsum();
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            foreach (m_frame[i]) m_frame[i] = 0;
            m_count = 0;
        end else if (q.size() < int'(DEPTH)) begin
            if (in_valid === 1'b1) begin
                m_frame[q.size()] = int'(in_data);
                q.push_back(int'(in_data));
            end
        end else if (out_ready === 1'b1) begin
            q.delete();
            m_count = m_count + 1;
        end
    end

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (q.size() < int'(DEPTH)) ? 1 : 0);
            chk("out_valid", out_valid, (q.size() == int'(DEPTH)) ? 1 : 0);
            chk("out_sum", out_sum, qsum());
            chk("frame_count", frame_count, m_count);
            for (int i = 0; i < int'(DEPTH); i++) begin
                chk($sformatf("out_frame[%0d]", i), out_frame[i], m_frame[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_data  = W'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic int rand_sample();
        logic signed [W-1:0] r;
        r = W'($urandom);
        return int'(r);
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        int guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for three cycles.
        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_out_sum", out_sum, 0);
        for (int i = 0; i < int'(DEPTH); i++) chk("rst_out_frame", out_frame[i], 0);

        // Basic frame 1..8.
        for (int i = 1; i <= int'(DEPTH); i++) begin
            push(i);
            if (i == int'(DEPTH) - 1) chk("basic_not_yet_valid", out_valid, 0);
        end
        chk("basic_out_valid", out_valid, 1);
        chk("basic_in_ready", in_ready, 0);
        chk("basic_sum", out_sum, 36);
        for (int i = 0; i < int'(DEPTH); i++) chk("basic_frame", out_frame[i], i + 1);
        step();
        chk("basic_hold_stable", out_valid, 1);
        handoff();
        chk("basic_handoff_valid", out_valid, 0);
        chk("basic_handoff_ready", in_ready, 1);
        chk("basic_count", frame_count, 1);
        chk("basic_sum_cleared", out_sum, 0);
        chk("basic_frame_kept", out_frame[DEPTH-1], 8);

        // Signed extremes.
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) push(-32);
        chk("neg_sum", out_sum, -256);
        handoff();
        for (int i = 0; i < int'(DEPTH); i++) push(31);
        chk("pos_sum", out_sum, 248);
        handoff();
        chk("extreme_count", frame_count, 2);

        // Random gaps, HOLD-phase valid ignored, out_ready in FILL ignored.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            guard = 0;
            while (out_valid !== 1'b1 && guard < 200) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = W'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                step();
                guard++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("rand_fill_done", out_valid, 1);
            for (int k = 0; k < 5; k++) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
                step();
            end
            in_valid = 1'b0;
            chk("rand_hold_in_ready", in_ready, 0);
            handoff();
            v = rand_sample();
            push(v);
            chk("rand_next_idx0", out_frame[0], v);
        end
        chk("rand_count", frame_count, 3);

        // Mid-frame reset discards the partial frame.
        do_reset();
        for (int i = 0; i < 5; i++) push(rand_sample());
        do_reset();
        for (int i = 10; i <= 17; i++) push(i);
        chk("midrst_valid", out_valid, 1);
        chk("midrst_sum", out_sum, 108);
        chk("midrst_idx0", out_frame[0], 10);
        handoff();
        chk("midrst_count", frame_count, 1);

        // Count wraps at the 32-bit signed boundary.
        dut.frame_count = 32'sh7fff_ffff;
        m_count         = 32'sh7fff_ffff;
        for (int i = 0; i < int'(DEPTH); i++) push(rand_sample());
        handoff();
        chk("wrap_count", frame_count, 32'sh8000_0000);

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
